// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states,
// captured-access payload and the access legality check.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_op_t;

    // 1 when the access must complete with an error and never reach the bus
    function automatic logic lsu_bad_access(input logic [2:0] funct3, input logic we,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (funct3)
            LSU_B:  bad = 1'b0;
            LSU_H:  bad = addr_lo[0];
            LSU_W:  bad = (addr_lo != 2'b00);
            LSU_BU: bad = we;
            LSU_HU: bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replicated write data, and
// load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        o_be      = 4'b0000;
        o_wdata   = '0;
        o_rdata   = '0;
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_funct3[2] ? {24'b0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_funct3[2] ? {16'b0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: accepts one access, runs a single data-bus
// transaction and returns extended load data with a one-cycle done pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_lsu_valid,
    input  logic        i_lsu_we,
    input  logic [2:0]  i_lsu_funct3,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    input  logic        i_lsu_flush,
    output logic        o_lsu_busy,
    output logic        o_lsu_done,
    output logic [31:0] o_lsu_rdata,
    output logic        o_lsu_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_rerr
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    lsu_op_t           r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       w_rdata_nxt;
    logic              w_err_nxt;
    logic              w_accept;
    logic              w_resp;
    logic              w_last;
    logic              w_in_req;
    logic [3:0]        w_be;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_load_data;

    lsu_align u_align (
        .i_funct3  (r_op.funct3),
        .i_addr_lo (r_op.addr[1:0]),
        .i_wdata   (r_op.wdata),
        .i_rdata   (i_bus_rdata),
        .o_be      (w_be),
        .o_wdata   (w_lane_wdata),
        .o_rdata   (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op.we     <= i_lsu_we;
                r_op.funct3 <= i_lsu_funct3;
                r_op.addr   <= i_lsu_addr;
                r_op.wdata  <= i_lsu_wdata;
            end
            // Counts REQ+WAIT cycles of the current access only
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_next == S_REQ || w_next == S_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_next == S_DONE && r_state != S_DONE) begin
                r_rdata <= w_rdata_nxt;
                r_err   <= w_err_nxt;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_resp      = 1'b0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = '0;
        w_last      = (r_cnt == CNT_LAST);
        case (r_state)
            S_IDLE: begin
                if (i_lsu_valid && !i_lsu_flush) begin
                    w_accept = 1'b1;
                    if (lsu_bad_access(i_lsu_funct3, i_lsu_we, i_lsu_addr[1:0])) begin
                        w_next    = S_DONE;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                // A response in REQ only counts when it rides on the grant
                w_resp = i_bus_rvalid && (r_state == S_WAIT || i_bus_gnt);
                if (w_resp) begin
                    w_next      = S_DONE;
                    w_err_nxt   = i_bus_rerr;
                    w_rdata_nxt = r_op.we ? 32'h0 : w_load_data;
                end else if (w_last) begin
                    w_next    = S_DONE;
                    w_err_nxt = 1'b1;
                end else if (r_state == S_REQ && i_bus_gnt) begin
                    w_next = S_WAIT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        w_in_req    = (r_state == S_REQ);
        o_lsu_busy  = w_in_req || (r_state == S_WAIT) || w_accept;
        o_lsu_done  = (r_state == S_DONE);
        o_lsu_rdata = r_rdata;
        o_lsu_err   = r_err;
        o_bus_req   = w_in_req;
        o_bus_we    = w_in_req && r_op.we;
        o_bus_addr  = w_in_req ? {r_op.addr[31:2], 2'b00} : 32'h0;
        o_bus_be    = w_in_req ? w_be : 4'b0000;
        o_bus_wdata = (w_in_req && r_op.we) ? w_lane_wdata : 32'h0;
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: table of accesses with a bus responder model
// and a result scoreboard, plus hand sequences for flush, stray rvalid and reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_lsu_valid, i_lsu_we, i_lsu_flush;
    logic [2:0]  i_lsu_funct3;
    logic [31:0] i_lsu_addr, i_lsu_wdata;
    logic        o_lsu_busy, o_lsu_done, o_lsu_err;
    logic [31:0] o_lsu_rdata;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_gnt, i_bus_rvalid, i_bus_rerr;
    logic [31:0] i_bus_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] brdata;
        logic        brerr;
        logic        flush_mid;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[16];

    lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_lsu_valid  (i_lsu_valid),
        .i_lsu_we     (i_lsu_we),
        .i_lsu_funct3 (i_lsu_funct3),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_wdata  (i_lsu_wdata),
        .i_lsu_flush  (i_lsu_flush),
        .o_lsu_busy   (o_lsu_busy),
        .o_lsu_done   (o_lsu_done),
        .o_lsu_rdata  (o_lsu_rdata),
        .o_lsu_err    (o_lsu_err),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_be     (o_bus_be),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_gnt    (i_bus_gnt),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata),
        .i_bus_rerr   (i_bus_rerr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                int g, int r, logic [31:0] brd, logic brerr, logic fl,
                                logic req, logic [3:0] be, logic [31:0] ewd,
                                logic [31:0] erd, logic eerr, int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.gnt_dly = g; v.rv_dly = r; v.brdata = brd; v.brerr = brerr; v.flush_mid = fl;
        v.exp_req = req; v.exp_be = be; v.exp_wdata = ewd;
        v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = lat;
        return v;
    endfunction

    function automatic logic [104:0] all_outputs();
        return {o_lsu_busy, o_lsu_done, o_lsu_rdata, o_lsu_err, o_bus_req, o_bus_we,
                o_bus_addr, o_bus_be, o_bus_wdata};
    endfunction

    // Drives one access, plays the bus slave per the vector, checks the result
    task automatic run_access(input int id, input vec_t v);
        exp_t e;
        exp_t got;
        int   req_cycles = 0;
        int   wait_cycles = 0;
        bit   granted = 0;
        bit   done_seen = 0;
        int   lat = 1;
        @(posedge clk); #1;
        i_lsu_valid = 1'b1; i_lsu_we = v.we; i_lsu_funct3 = v.f3;
        i_lsu_addr = v.addr; i_lsu_wdata = v.wdata; i_lsu_flush = 1'b0;
        #1;
        check($sformatf("v%0d_busy_accept", id), 128'(o_lsu_busy), 128'(1));
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        sb_q.push_back(e);
        @(posedge clk); #1;
        i_lsu_valid = v.flush_mid;
        i_lsu_flush = v.flush_mid;
        for (int cyc = 0; cyc < 40; cyc++) begin
            i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rerr = 1'b0; i_bus_rdata = 32'h0;
            if (o_lsu_done) begin
                i_lsu_valid = 1'b0; i_lsu_flush = 1'b0;
                done_seen = 1;
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d_sb_empty", id), 128'(1), 128'(0));
                end else begin
                    got = sb_q.pop_front();
                    check($sformatf("v%0d_rdata", id), 128'(o_lsu_rdata), 128'(got.rdata));
                    check($sformatf("v%0d_err", id), 128'(o_lsu_err), 128'(got.err));
                    check($sformatf("v%0d_latency", id), 128'(lat), 128'(got.lat));
                end
                check($sformatf("v%0d_done_busy_req", id), 128'({o_lsu_busy, o_bus_req}), 128'(0));
                break;
            end
            check($sformatf("v%0d_busy", id), 128'(o_lsu_busy), 128'(1));
            if (o_bus_req) begin
                check($sformatf("v%0d_bus", id),
                      128'({o_bus_req, o_bus_we, o_bus_addr, o_bus_be, (v.we ? o_bus_wdata : 32'h0)}),
                      128'({v.exp_req, v.we, v.addr[31:2], 2'b00, v.exp_be, (v.we ? v.exp_wdata : 32'h0)}));
                if (req_cycles == v.gnt_dly) begin
                    i_bus_gnt = 1'b1;
                    granted = 1;
                    if (v.rv_dly == 0) begin
                        i_bus_rvalid = 1'b1; i_bus_rdata = v.brdata; i_bus_rerr = v.brerr;
                    end
                end
                req_cycles++;
            end else if (granted) begin
                wait_cycles++;
                if (wait_cycles == v.rv_dly) begin
                    i_bus_rvalid = 1'b1; i_bus_rdata = v.brdata; i_bus_rerr = v.brerr;
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!done_seen) check($sformatf("v%0d_done_timeout", id), 128'(0), 128'(1));
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rerr = 1'b0;
        i_lsu_valid = 1'b0; i_lsu_flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_lsu_valid = 1'b0; i_lsu_we = 1'b0; i_lsu_funct3 = 3'b000; i_lsu_flush = 1'b0;
        i_lsu_addr = 32'h0; i_lsu_wdata = 32'h0;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'h0; i_bus_rerr = 1'b0;

        //            we   f3     addr          wdata        g    r    brdata        rerr fl   req  be       ewdata        erdata        err  lat
        vecs[0]  = mk(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0,   1,   32'h0,        1'b0, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 3);
        vecs[1]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        0,   1,   32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 3);
        vecs[2]  = mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,        0,   1,   32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,        32'h0000_0080, 1'b0, 3);
        vecs[3]  = mk(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 0,   1,   32'h0,        1'b0, 1'b0, 1'b1, 4'b1100, 32'h1234_1234, 32'h0,        1'b0, 3);
        vecs[4]  = mk(1'b0, 3'b001, 32'h0000_0101, 32'h0,        0,   1,   32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
        vecs[5]  = mk(1'b0, 3'b010, 32'h0000_0204, 32'h0,        4,   1,   32'h1122_3344, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0,        32'h1122_3344, 1'b1, 7);
        vecs[6]  = mk(1'b0, 3'b010, 32'h0000_0300, 32'h0,        255, 1,   32'h0,        1'b0, 1'b0, 1'b1, 4'b1111, 32'h0,        32'h0,        1'b1, 9);
        vecs[7]  = mk(1'b0, 3'b001, 32'h0000_0202, 32'h0,        2,   0,   32'h8001_0000, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 4);
        vecs[8]  = mk(1'b0, 3'b101, 32'h0000_0202, 32'h0,        0,   3,   32'h8001_0000, 1'b0, 1'b1, 1'b1, 4'b1100, 32'h0,        32'h0000_8001, 1'b0, 5);
        vecs[9]  = mk(1'b1, 3'b000, 32'h0000_0101, 32'hFFFF_FFA5, 1,   2,   32'h0,        1'b0, 1'b0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 5);
        vecs[10] = mk(1'b0, 3'b010, 32'h0000_0400, 32'h0,        0,   255, 32'h0,        1'b0, 1'b0, 1'b1, 4'b1111, 32'h0,        32'h0,        1'b1, 9);
        vecs[11] = mk(1'b1, 3'b010, 32'h0000_0102, 32'h5555_5555, 0,   1,   32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
        vecs[12] = mk(1'b0, 3'b011, 32'h0000_0000, 32'h0,        0,   1,   32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
        vecs[13] = mk(1'b0, 3'b000, 32'h0000_0101, 32'h0,        0,   1,   32'h0000_7F00, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0,        32'h0000_007F, 1'b0, 3);
        vecs[14] = mk(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 3,   0,   32'h0,        1'b1, 1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b1, 5);
        vecs[15] = mk(1'b1, 3'b100, 32'h0000_0000, 32'h0000_0011, 0,   1,   32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 128'(all_outputs()), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", 128'(all_outputs()), 128'(0));

        for (int i = 0; i < 16; i++) run_access(i, vecs[i]);
        check("sb_drained", 128'(sb_q.size()), 128'(0));

        // valid and flush together: nothing accepted
        @(posedge clk); #1;
        i_lsu_valid = 1'b1; i_lsu_we = 1'b1; i_lsu_funct3 = 3'b010;
        i_lsu_addr = 32'h0000_0800; i_lsu_flush = 1'b1;
        #1;
        check("flush_busy", 128'(o_lsu_busy), 128'(0));
        @(posedge clk); #1;
        i_lsu_valid = 1'b0; i_lsu_flush = 1'b0;
        check("flush_no_req", 128'({o_bus_req, o_lsu_done, o_lsu_busy}), 128'(0));
        @(posedge clk); #1;
        check("flush_no_done", 128'({o_bus_req, o_lsu_done}), 128'(0));

        // stray response in IDLE is ignored
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFFFF_FFFF; i_bus_gnt = 1'b1;
        @(posedge clk); #1;
        i_bus_rvalid = 1'b0; i_bus_rdata = 32'h0; i_bus_gnt = 1'b0;
        check("stray_rvalid", 128'({o_lsu_done, o_bus_req, o_lsu_busy}), 128'(0));

        // reset asserted while WAITing for a response
        @(posedge clk); #1;
        i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_lsu_funct3 = 3'b010; i_lsu_addr = 32'h0000_0500;
        @(posedge clk); #1;
        i_lsu_valid = 1'b0;
        check("rst_seq_req", 128'({o_bus_req, o_bus_addr}), 128'({1'b1, 32'h0000_0500}));
        i_bus_gnt = 1'b1;
        @(posedge clk); #1;
        i_bus_gnt = 1'b0;
        check("rst_seq_wait", 128'({o_lsu_busy, o_bus_req, o_lsu_err}), 128'({1'b1, 1'b0, 1'b1}));
        #2 rst = 1'b1;
        #1;
        check("rst_in_wait", 128'(all_outputs()), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", 128'(all_outputs()), 128'(0));

        run_access(16, vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
